// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared encodings for the multi-cycle CPU control path.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WBK    = 3'd4
    } state_t;

    // Execution-path classes; every ALU-style instruction shares F-D-E-W.
    typedef enum logic [2:0] {
        CL_ALU = 3'd0,
        CL_LW  = 3'd1,
        CL_SW  = 3'd2,
        CL_BEQ = 3'd3,
        CL_J   = 3'd4,
        CL_JAL = 3'd5,
        CL_ILL = 3'd6
    } inst_class_t;

    localparam logic [1:0] c_type_r = 2'b00;
    localparam logic [1:0] c_type_j = 2'b01;
    localparam logic [1:0] c_type_i = 2'b10;
    localparam logic [1:0] c_type_s = 2'b11;

    localparam logic [4:0] c_fn_and  = 5'd0;
    localparam logic [4:0] c_fn_add  = 5'd1;
    localparam logic [4:0] c_fn_sub  = 5'd2;
    localparam logic [4:0] c_fn_cmp  = 5'd3;

    localparam logic [4:0] c_fn_andi = 5'd0;
    localparam logic [4:0] c_fn_addi = 5'd1;
    localparam logic [4:0] c_fn_lw   = 5'd2;
    localparam logic [4:0] c_fn_sw   = 5'd3;
    localparam logic [4:0] c_fn_beq  = 5'd4;

    localparam logic [4:0] c_fn_j    = 5'd0;
    localparam logic [4:0] c_fn_jal  = 5'd1;

    localparam logic [4:0] c_fn_sll  = 5'd0;
    localparam logic [4:0] c_fn_srl  = 5'd1;
    localparam logic [4:0] c_fn_sllv = 5'd2;
    localparam logic [4:0] c_fn_srlv = 5'd3;

    localparam logic [3:0] c_alu_and = 4'd0;
    localparam logic [3:0] c_alu_add = 4'd1;
    localparam logic [3:0] c_alu_sub = 4'd2;
    localparam logic [3:0] c_alu_sll = 4'd3;
    localparam logic [3:0] c_alu_srl = 4'd4;

    localparam logic [1:0] c_pc_inc    = 2'd0;
    localparam logic [1:0] c_pc_target = 2'd1;
    localparam logic [1:0] c_pc_stack  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/cu_decode.sv
// ============================================================================
// Module      : cu_decode
// Description : Maps IR type/function to instruction class and static selects.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cu_decode
    import cpu_pkg::*;
(
    input  logic [1:0]  i_inst_type,
    input  logic [4:0]  i_inst_function,
    output inst_class_t o_inst_class,
    output logic        o_illegal,
    output logic [3:0]  o_alu_op,
    output logic        o_alu_src,
    output logic        o_ex_src,
    output logic        o_ex_s,
    output logic        o_rs2_src
);

    always_comb begin
        o_inst_class = CL_ILL;
        o_alu_op     = c_alu_and;
        o_alu_src    = 1'b0;
        o_ex_src     = 1'b0;
        o_ex_s       = 1'b0;
        o_rs2_src    = 1'b0;
        case (i_inst_type)
            c_type_r: begin
                case (i_inst_function)
                    c_fn_and: begin o_inst_class = CL_ALU; o_alu_op = c_alu_and; end
                    c_fn_add: begin o_inst_class = CL_ALU; o_alu_op = c_alu_add; end
                    c_fn_sub: begin o_inst_class = CL_ALU; o_alu_op = c_alu_sub; end
                    c_fn_cmp: begin o_inst_class = CL_ALU; o_alu_op = c_alu_sub; end
                    default:  o_inst_class = CL_ILL;
                endcase
            end
            c_type_i: begin
                case (i_inst_function)
                    c_fn_andi: begin
                        o_inst_class = CL_ALU;
                        o_alu_src    = 1'b1;
                    end
                    c_fn_addi: begin
                        o_inst_class = CL_ALU;
                        o_alu_op     = c_alu_add;
                        o_alu_src    = 1'b1;
                        o_ex_s       = 1'b1;
                    end
                    c_fn_lw: begin
                        o_inst_class = CL_LW;
                        o_alu_op     = c_alu_add;
                        o_alu_src    = 1'b1;
                        o_ex_s       = 1'b1;
                    end
                    c_fn_sw: begin
                        o_inst_class = CL_SW;
                        o_alu_op     = c_alu_add;
                        o_alu_src    = 1'b1;
                        o_ex_s       = 1'b1;
                        o_rs2_src    = 1'b1;
                    end
                    c_fn_beq: begin
                        o_inst_class = CL_BEQ;
                        o_alu_op     = c_alu_sub;
                        o_rs2_src    = 1'b1;
                    end
                    default: o_inst_class = CL_ILL;
                endcase
            end
            c_type_j: begin
                case (i_inst_function)
                    c_fn_j:   o_inst_class = CL_J;
                    c_fn_jal: o_inst_class = CL_JAL;
                    default:  o_inst_class = CL_ILL;
                endcase
            end
            default: begin
                // Immediate shifts take the amount from the 5-bit field via the extender.
                case (i_inst_function)
                    c_fn_sll: begin
                        o_inst_class = CL_ALU;
                        o_alu_op     = c_alu_sll;
                        o_alu_src    = 1'b1;
                        o_ex_src     = 1'b1;
                    end
                    c_fn_srl: begin
                        o_inst_class = CL_ALU;
                        o_alu_op     = c_alu_srl;
                        o_alu_src    = 1'b1;
                        o_ex_src     = 1'b1;
                    end
                    c_fn_sllv: begin o_inst_class = CL_ALU; o_alu_op = c_alu_sll; end
                    c_fn_srlv: begin o_inst_class = CL_ALU; o_alu_op = c_alu_srl; end
                    default:   o_inst_class = CL_ILL;
                endcase
            end
        endcase
    end

    assign o_illegal = (o_inst_class == CL_ILL);

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle control FSM sequencing the 32-bit CPU datapath.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] inst_type,
    input  logic [4:0] inst_function,
    input  logic       stop_bit,
    input  logic       zero_flag,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] PCsrc,
    output logic [3:0] ALUop,
    output logic       ALUsrc,
    output logic       ExSrc,
    output logic       ExS,
    output logic       RS2src,
    output logic       WB,
    output logic       WBdata,
    output logic       MemR,
    output logic       MemW,
    output logic       StR,
    output logic       StW,
    output logic [2:0] state,
    output logic       illegal
);

    state_t      r_state;
    inst_class_t w_class;
    logic        w_dec_illegal;
    logic [3:0]  w_dec_alu_op;
    logic        w_dec_alu_src;
    logic        w_dec_ex_src;
    logic        w_dec_ex_s;
    logic        w_dec_rs2_src;

    logic        w_datapath;
    logic        w_last;
    logic        w_ir_write;
    logic        w_pc_write;
    logic [1:0]  w_pc_src;
    logic        w_wb;
    logic        w_wb_data;
    logic        w_mem_r;
    logic        w_mem_w;
    logic        w_st_r;
    logic        w_st_w;
    logic        w_illegal;

    cu_decode u_decode (
        .i_inst_type     (inst_type),
        .i_inst_function (inst_function),
        .o_inst_class    (w_class),
        .o_illegal       (w_dec_illegal),
        .o_alu_op        (w_dec_alu_op),
        .o_alu_src       (w_dec_alu_src),
        .o_ex_src        (w_dec_ex_src),
        .o_ex_s          (w_dec_ex_s),
        .o_rs2_src       (w_dec_rs2_src)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            case (r_state)
                FETCH:  r_state <= DECODE;
                DECODE: begin
                    if (w_class == CL_J || w_class == CL_JAL || w_dec_illegal)
                        r_state <= FETCH;
                    else
                        r_state <= EXEC;
                end
                EXEC: begin
                    if (w_class == CL_BEQ)
                        r_state <= FETCH;
                    else if (w_class == CL_LW || w_class == CL_SW)
                        r_state <= MEM;
                    else
                        r_state <= WBK;
                end
                MEM:     r_state <= (w_class == CL_LW) ? WBK : FETCH;
                default: r_state <= FETCH;
            endcase
        end
    end

    always_comb begin
        w_datapath = 1'b0;
        w_last     = 1'b0;
        w_ir_write = 1'b0;
        w_pc_write = 1'b0;
        w_pc_src   = c_pc_inc;
        w_wb       = 1'b0;
        w_wb_data  = 1'b0;
        w_mem_r    = 1'b0;
        w_mem_w    = 1'b0;
        w_st_r     = 1'b0;
        w_st_w     = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            FETCH: w_ir_write = 1'b1;
            DECODE: begin
                if (w_class == CL_J || w_class == CL_JAL) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = c_pc_target;
                    w_st_w     = (w_class == CL_JAL);
                end else if (w_dec_illegal) begin
                    w_illegal  = 1'b1;
                    w_pc_write = 1'b1;
                end
            end
            EXEC: begin
                w_datapath = 1'b1;
                w_last     = (w_class == CL_BEQ);
            end
            MEM: begin
                w_datapath = 1'b1;
                w_mem_r    = (w_class == CL_LW);
                w_mem_w    = (w_class == CL_SW);
                w_last     = (w_class == CL_SW);
            end
            WBK: begin
                w_datapath = 1'b1;
                w_wb       = 1'b1;
                w_wb_data  = (w_class == CL_LW);
                w_last     = 1'b1;
            end
            default: ;
        endcase
        // A taken branch wins over the stop bit, so it never pops the stack.
        if (w_last) begin
            w_pc_write = 1'b1;
            if (w_class == CL_BEQ && zero_flag) begin
                w_pc_src = c_pc_target;
            end else if (stop_bit) begin
                w_pc_src = c_pc_stack;
                w_st_r   = 1'b1;
            end
        end
    end

    assign ALUop  = w_datapath ? w_dec_alu_op  : c_alu_and;
    assign ALUsrc = w_datapath & w_dec_alu_src;
    assign ExSrc  = w_datapath & w_dec_ex_src;
    assign ExS    = w_datapath & w_dec_ex_s;
    assign RS2src = w_datapath & w_dec_rs2_src;
    assign PCsrc  = w_pc_src;
    assign WBdata = w_wb_data;
    assign state  = r_state;

    // Strobes are gated by rst_n so nothing fires while reset is held.
    assign ir_write = w_ir_write & rst_n;
    assign pc_write = w_pc_write & rst_n;
    assign WB       = w_wb       & rst_n;
    assign MemR     = w_mem_r    & rst_n;
    assign MemW     = w_mem_w    & rst_n;
    assign StR      = w_st_r     & rst_n;
    assign StW      = w_st_w     & rst_n;
    assign illegal  = w_illegal  & rst_n;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module      : tb_control_unit
// Description : Table-driven self-checking bench for control_unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [1:0] inst_type;
    logic [4:0] inst_function;
    logic       stop_bit;
    logic       zero_flag;
    logic       ir_write, pc_write;
    logic [1:0] PCsrc;
    logic [3:0] ALUop;
    logic       ALUsrc, ExSrc, ExS, RS2src, WB, WBdata;
    logic       MemR, MemW, StR, StW, illegal;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    control_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_type     (inst_type),
        .inst_function (inst_function),
        .stop_bit      (stop_bit),
        .zero_flag     (zero_flag),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .PCsrc         (PCsrc),
        .ALUop         (ALUop),
        .ALUsrc        (ALUsrc),
        .ExSrc         (ExSrc),
        .ExS           (ExS),
        .RS2src        (RS2src),
        .WB            (WB),
        .WBdata        (WBdata),
        .MemR          (MemR),
        .MemW          (MemW),
        .StR           (StR),
        .StW           (StW),
        .state         (state),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout: ir pw pcs[2] aluop[4] asrc exsrc exs rs2 wb wbd mr mw str stw ill
    typedef struct packed {
        logic [1:0]  t;
        logic [4:0]  f;
        logic        s;
        logic        z;
        logic [2:0]  st;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [18:0] c_f = 19'b1_0_00_0000_0000_0000_000;
    localparam logic [18:0] c_d = 19'b0_0_00_0000_0000_0000_000;

    function automatic vec_t mk(input logic [1:0] t, input logic [4:0] f, input logic s,
                                input logic z, input logic [2:0] st, input logic [18:0] e);
        vec_t v;
        v.t = t; v.f = f; v.s = s; v.z = z; v.st = st; v.exp = e;
        return v;
    endfunction

    function automatic logic [18:0] outs();
        return {ir_write, pc_write, PCsrc, ALUop, ALUsrc, ExSrc, ExS, RS2src,
                WB, WBdata, MemR, MemW, StR, StW, illegal};
    endfunction

    function automatic logic [7:0] strobes();
        return {ir_write, pc_write, WB, MemR, MemW, StR, StW, illegal};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic [1:0] t, input logic [4:0] f, input logic s, input logic z);
        inst_type = t; inst_function = f; stop_bit = s; zero_flag = z;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'd0, 5'd0, 1'b0, 1'b0);

        // ADD, zero_flag high must not redirect a non-branch
        vecs.push_back(mk(2'd0, 5'd1, 1'b0, 1'b1, 3'd0, c_f));
        vecs.push_back(mk(2'd0, 5'd1, 1'b0, 1'b1, 3'd1, c_d));
        vecs.push_back(mk(2'd0, 5'd1, 1'b0, 1'b1, 3'd2, 19'b0_0_00_0001_0000_0000_000));
        vecs.push_back(mk(2'd0, 5'd1, 1'b0, 1'b1, 3'd4, 19'b0_1_00_0001_0000_1000_000));
        // LW
        vecs.push_back(mk(2'd2, 5'd2, 1'b0, 1'b0, 3'd0, c_f));
        vecs.push_back(mk(2'd2, 5'd2, 1'b0, 1'b0, 3'd1, c_d));
        vecs.push_back(mk(2'd2, 5'd2, 1'b0, 1'b0, 3'd2, 19'b0_0_00_0001_1010_0000_000));
        vecs.push_back(mk(2'd2, 5'd2, 1'b0, 1'b0, 3'd3, 19'b0_0_00_0001_1010_0010_000));
        vecs.push_back(mk(2'd2, 5'd2, 1'b0, 1'b0, 3'd4, 19'b0_1_00_0001_1010_1100_000));
        // SW
        vecs.push_back(mk(2'd2, 5'd3, 1'b0, 1'b0, 3'd0, c_f));
        vecs.push_back(mk(2'd2, 5'd3, 1'b0, 1'b0, 3'd1, c_d));
        vecs.push_back(mk(2'd2, 5'd3, 1'b0, 1'b0, 3'd2, 19'b0_0_00_0001_1011_0000_000));
        vecs.push_back(mk(2'd2, 5'd3, 1'b0, 1'b0, 3'd3, 19'b0_1_00_0001_1011_0001_000));
        // BEQ taken with stop: branch wins, no pop
        vecs.push_back(mk(2'd2, 5'd4, 1'b1, 1'b1, 3'd0, c_f));
        vecs.push_back(mk(2'd2, 5'd4, 1'b1, 1'b1, 3'd1, c_d));
        vecs.push_back(mk(2'd2, 5'd4, 1'b1, 1'b1, 3'd2, 19'b0_1_01_0010_0001_0000_000));
        // BEQ not taken with stop: pop
        vecs.push_back(mk(2'd2, 5'd4, 1'b1, 1'b0, 3'd0, c_f));
        vecs.push_back(mk(2'd2, 5'd4, 1'b1, 1'b0, 3'd1, c_d));
        vecs.push_back(mk(2'd2, 5'd4, 1'b1, 1'b0, 3'd2, 19'b0_1_10_0010_0001_0000_100));
        // BEQ not taken, no stop
        vecs.push_back(mk(2'd2, 5'd4, 1'b0, 1'b0, 3'd0, c_f));
        vecs.push_back(mk(2'd2, 5'd4, 1'b0, 1'b0, 3'd1, c_d));
        vecs.push_back(mk(2'd2, 5'd4, 1'b0, 1'b0, 3'd2, 19'b0_1_00_0010_0001_0000_000));
        // JAL (stop ignored)
        vecs.push_back(mk(2'd1, 5'd1, 1'b1, 1'b0, 3'd0, c_f));
        vecs.push_back(mk(2'd1, 5'd1, 1'b1, 1'b0, 3'd1, 19'b0_1_01_0000_0000_0000_010));
        // J
        vecs.push_back(mk(2'd1, 5'd0, 1'b0, 1'b0, 3'd0, c_f));
        vecs.push_back(mk(2'd1, 5'd0, 1'b0, 1'b0, 3'd1, 19'b0_1_01_0000_0000_0000_000));
        // Illegal R/7 with stop (ignored)
        vecs.push_back(mk(2'd0, 5'd7, 1'b1, 1'b0, 3'd0, c_f));
        vecs.push_back(mk(2'd0, 5'd7, 1'b1, 1'b0, 3'd1, 19'b0_1_00_0000_0000_0000_001));
        // Illegal I/5 and J/2
        vecs.push_back(mk(2'd2, 5'd5, 1'b0, 1'b0, 3'd0, c_f));
        vecs.push_back(mk(2'd2, 5'd5, 1'b0, 1'b0, 3'd1, 19'b0_1_00_0000_0000_0000_001));
        vecs.push_back(mk(2'd1, 5'd2, 1'b0, 1'b0, 3'd0, c_f));
        vecs.push_back(mk(2'd1, 5'd2, 1'b0, 1'b0, 3'd1, 19'b0_1_00_0000_0000_0000_001));
        // ADDI with stop: return via stack
        vecs.push_back(mk(2'd2, 5'd1, 1'b1, 1'b0, 3'd0, c_f));
        vecs.push_back(mk(2'd2, 5'd1, 1'b1, 1'b0, 3'd1, c_d));
        vecs.push_back(mk(2'd2, 5'd1, 1'b1, 1'b0, 3'd2, 19'b0_0_00_0001_1010_0000_000));
        vecs.push_back(mk(2'd2, 5'd1, 1'b1, 1'b0, 3'd4, 19'b0_1_10_0001_1010_1000_100));
        // ANDI zero-extends
        vecs.push_back(mk(2'd2, 5'd0, 1'b0, 1'b0, 3'd0, c_f));
        vecs.push_back(mk(2'd2, 5'd0, 1'b0, 1'b0, 3'd1, c_d));
        vecs.push_back(mk(2'd2, 5'd0, 1'b0, 1'b0, 3'd2, 19'b0_0_00_0000_1000_0000_000));
        vecs.push_back(mk(2'd2, 5'd0, 1'b0, 1'b0, 3'd4, 19'b0_1_00_0000_1000_1000_000));
        // SLL immediate shift
        vecs.push_back(mk(2'd3, 5'd0, 1'b0, 1'b0, 3'd0, c_f));
        vecs.push_back(mk(2'd3, 5'd0, 1'b0, 1'b0, 3'd1, c_d));
        vecs.push_back(mk(2'd3, 5'd0, 1'b0, 1'b0, 3'd2, 19'b0_0_00_0011_1100_0000_000));
        vecs.push_back(mk(2'd3, 5'd0, 1'b0, 1'b0, 3'd4, 19'b0_1_00_0011_1100_1000_000));
        // SRLV register shift
        vecs.push_back(mk(2'd3, 5'd3, 1'b0, 1'b0, 3'd0, c_f));
        vecs.push_back(mk(2'd3, 5'd3, 1'b0, 1'b0, 3'd1, c_d));
        vecs.push_back(mk(2'd3, 5'd3, 1'b0, 1'b0, 3'd2, 19'b0_0_00_0100_0000_0000_000));
        vecs.push_back(mk(2'd3, 5'd3, 1'b0, 1'b0, 3'd4, 19'b0_1_00_0100_0000_1000_000));
        // CMP uses SUB
        vecs.push_back(mk(2'd0, 5'd3, 1'b0, 1'b0, 3'd0, c_f));
        vecs.push_back(mk(2'd0, 5'd3, 1'b0, 1'b0, 3'd1, c_d));
        vecs.push_back(mk(2'd0, 5'd3, 1'b0, 1'b0, 3'd2, 19'b0_0_00_0010_0000_0000_000));
        vecs.push_back(mk(2'd0, 5'd3, 1'b0, 1'b0, 3'd4, 19'b0_1_00_0010_0000_1000_000));
        // SW with stop: pop on completion in MEM
        vecs.push_back(mk(2'd2, 5'd3, 1'b1, 1'b0, 3'd0, c_f));
        vecs.push_back(mk(2'd2, 5'd3, 1'b1, 1'b0, 3'd1, c_d));
        vecs.push_back(mk(2'd2, 5'd3, 1'b1, 1'b0, 3'd2, 19'b0_0_00_0001_1011_0000_000));
        vecs.push_back(mk(2'd2, 5'd3, 1'b1, 1'b0, 3'd3, 19'b0_1_10_0001_1011_0001_100));

        // Reset held across clock edges: state FETCH, strobes gated
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_strobes", 32'(strobes()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].t, vecs[i].f, vecs[i].s, vecs[i].z);
            #1;
            chk($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("row%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
            @(negedge clk);
        end

        // Asynchronous reset in the middle of an LW (MEM state)
        drive(2'd2, 5'd2, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("midlw_mem_state", 32'(state), 32'd3);
        chk("midlw_memr", 32'(MemR), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_state", 32'(state), 32'd0);
        chk("async_reset_strobes", 32'(strobes()), 32'd0);
        @(negedge clk);
        #1;
        chk("held_reset_state", 32'(state), 32'd0);
        chk("held_reset_strobes", 32'(strobes()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_state", 32'(state), 32'd0);
        chk("release_outs", 32'(outs()), 32'(c_f));
        @(negedge clk);
        #1;
        chk("release_decode", 32'(state), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_unit.md
# control_unit

Multi-cycle control FSM for the 32-bit CPU. It sits directly upstream of the datapath: it consumes the instruction fields latched in the IR plus the ALU zero flag, and sequences every select, enable and write strobe the datapath muxes, register file, data memory, stack and PC register consume. Each instruction takes 2–5 cycles.

## Interface
- No parameters; all encodings come from `cpu_pkg`.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inst_type` in 2: IR type field; 00 = R, 01 = J, 10 = I, 11 = S.
- `inst_function` in 5: IR function field.
- `stop_bit` in 1: IR stop bit.
- `zero_flag` in 1: ALU zero output, combinational from the datapath.
- `ir_write`, `pc_write` out 1: IR load enable and PC load enable.
- `PCsrc` out 2: PC source; 0 = PC+1, 1 = jump/branch target, 2 = stack top.
- `ALUop` out 4: ALU operation; AND = 0, ADD = 1, SUB = 2, SLL = 3, SRL = 4.
- `ALUsrc` out 1: ALU operand B; 0 = register, 1 = extended immediate.
- `ExSrc` out 1: extender input; 0 = 16-bit immediate, 1 = 5-bit shift amount.
- `ExS` out 1: extender mode; 1 = sign-extend, 0 = zero-extend.
- `RS2src` out 1: register-file port B address; 0 = Rs2 field, 1 = Rd field.
- `WB`, `WBdata` out 1: register write enable; write-back source (0 = ALU, 1 = memory).
- `MemR`, `MemW` out 1: data-memory read and write strobes.
- `StR`, `StW` out 1: stack pop and push strobes.
- `state` out 3: current state, for debug and bench use.
- `illegal` out 1: undefined opcode flag.

## Operation
- Opcode set, as type/function:
  - R: AND 0, ADD 1, SUB 2, CMP 3.
  - I: ANDI 0, ADDI 1, LW 2, SW 3, BEQ 4.
  - J: J 0, JAL 1.
  - S: SLL 0, SRL 1, SLLV 2, SRLV 3.
- Any other type/function combination is illegal.
- States are FETCH 0, DECODE 1, EXEC 2, MEM 3, WBK 4.
- Paths per instruction:
  - R/S: F → D → E → W.
  - ANDI, ADDI: F → D → E → W.
  - LW: F → D → E → M → W.
  - SW: F → D → E → M.
  - BEQ: F → D → E.
  - J, JAL, illegal: F → D.
- FETCH: `ir_write` = 1.
- DECODE:
  - J/JAL: `pc_write` = 1 and `PCsrc` = 1.
  - JAL additionally: `StW` = 1, which pushes PC+1.
  - Illegal: `illegal` = 1, `pc_write` = 1, `PCsrc` = 0.
- EXEC through the last state: ALU and extender controls are driven and held stable.
  - ANDI: `ExS` = 0, `ALUsrc` = 1.
  - ADDI, LW, SW: `ExS` = 1, `ALUsrc` = 1.
  - SLL, SRL: `ExSrc` = 1, `ALUsrc` = 1.
  - SLLV, SRLV: `ALUsrc` = 0.
  - CMP, BEQ: `ALUop` = SUB.
  - SW, BEQ: `RS2src` = 1.
- MEM: `MemR` = 1 for LW; `MemW` = 1 for SW.
- WBK: `WB` = 1; `WBdata` = 1 for LW only.
- Completion (last state of every non-jump, non-illegal instruction) asserts `pc_write`, with PCsrc chosen by priority:
  1. BEQ with `zero_flag` = 1: `PCsrc` = 1.
  2. Otherwise, `stop_bit` = 1: `PCsrc` = 2 and `StR` = 1 (pop).
  3. Otherwise: `PCsrc` = 0.
- The stop bit is ignored on J, JAL and illegal instructions.
- A taken BEQ with the stop bit set does not pop the stack.
- All outputs not listed for a state are 0.

## Timing
- The state register updates on the rising `clk` edge.
- Outputs are combinational from the state register and the IR fields (Moore with field decode).
- IR fields are valid from DECODE onward; `zero_flag` is sampled in BEQ's EXEC cycle.
- Reset:
  - `rst_n` low forces `state` = FETCH immediately, asynchronously.
  - While `rst_n` is low, all strobes are gated to 0: `ir_write`, `pc_write`, `WB`, `MemR`, `MemW`, `StR`, `StW`, `illegal`.
  - The first `ir_write` pulse occurs in the first cycle after release.
- Reset mid-instruction abandons it with no further strobes.
- Exactly one `pc_write` pulse occurs per instruction, always in its final cycle.

## Structure
- `cpu_pkg` holds:
  - the state enum;
  - type and function codes;
  - ALUop and PCsrc encodings.
- One sub-module, `cu_decode`: combinational mapping of type/function to instruction class, illegal flag and static datapath selects.
- The FSM and strobe gating live in `control_unit`.

## Test plan
- Reset low mid-LW (in MEM), then release → `state` = 0, all strobes 0 during reset; `ir_write` = 1 on the first cycle after release.
- ADD (type 00, function 1) → states 0,1,2,4; `ALUop` = 1 in E and W; `WB` = 1 in W only; `pc_write` with `PCsrc` = 0 in W.
- LW, then SW → 5 and 4 cycles respectively:
  - LW: `MemR` in M, `WBdata` = 1 with `WB` in W.
  - SW: `MemW` in M, `RS2src` = 1, `WB` never asserted.
- BEQ with `zero_flag` = 1 and `stop_bit` = 1 → 3 cycles; `PCsrc` = 1 and `StR` = 0. Repeat with `zero_flag` = 0 → `PCsrc` = 2 and `StR` = 1.
- JAL → 2 cycles; `StW` = 1, `pc_write` = 1, `PCsrc` = 1 in DECODE.
- Type 00, function 7 → `illegal` = 1 in DECODE, `PCsrc` = 0, then back to FETCH.
